// File: rtl/wddl_word_decoder.sv
// WDDL dual-rail word decoder: waits for a full spacer, evaluates one
// word per phase, holds it until the consumer takes it.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   In_T, In_F     : true/false rails of the WDDL word
//   Out, out_valid : registered decoded word and its valid flag
//   out_ready      : consumer accepts Out (ignored while out_valid is 0)
//   code_err       : one-cycle pulse on an illegal 11 code
//   timeout        : one-cycle pulse when evaluation is aborted
//   alarm          : sticky fail-secure alarm (only with WDDL_ALARM_EN)
//
// Build option: define WDDL_ALARM_EN to add the fail-secure alarm.
module wddl_word_decoder #(
  parameter int WORD    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] In_T,
  input  logic [WORD-1:0] In_F,
  output logic [WORD-1:0] Out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            code_err,
`ifdef WDDL_ALARM_EN
  output logic            timeout,
  output logic            alarm
`else
  output logic            timeout
`endif
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    PRE  = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WORD-1:0] out_q;
  logic            out_valid_q;
  logic            code_err_q;
  logic            timeout_q;
  logic [7:0]      cnt_q, cnt_d;

  logic            capture;
  logic            valid_d;
  logic            err_d;
  logic            tmo_d;
  logic            inhibit;

  logic all_spacer;
  logic all_valid;
  logic any_illegal;

  assign all_spacer  = ~|(In_T | In_F);
  assign all_valid   = &(In_T ^ In_F);
  assign any_illegal = |(In_T & In_F);

`ifdef WDDL_ALARM_EN
  logic alarm_q;
  assign inhibit = alarm_q;
  assign alarm   = alarm_q;
`else
  assign inhibit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PRE: begin
        if (all_spacer) state_d = EVAL;
      end
      EVAL: begin
        if (any_illegal) begin
          state_d = PRE;
        end else if (all_valid) begin
          // a word seen under alarm is consumed, never held
          state_d = inhibit ? PRE : HOLD;
        end else if (cnt_q >= TMO) begin
          state_d = PRE;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) state_d = PRE;
      end
      default: state_d = PRE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    valid_d = out_valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      PRE: begin
        err_d = any_illegal;
        if (all_spacer) cnt_d = '0;
      end
      EVAL: begin
        if (any_illegal) begin
          err_d = 1'b1;
        end else if (all_valid) begin
          capture = !inhibit;
          valid_d = !inhibit;
        end else if (cnt_q >= TMO) begin
          tmo_d = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
`ifdef WDDL_ALARM_EN
      alarm_q     <= 1'b0;
`endif
    end else begin
      out_valid_q <= valid_d;
      code_err_q  <= err_d;
      timeout_q   <= tmo_d;
      cnt_q       <= cnt_d;
      if (capture) out_q <= In_T;
`ifdef WDDL_ALARM_EN
      alarm_q <= alarm_q | err_d | tmo_d;
      if (alarm_q | err_d | tmo_d) begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end
`endif
    end
  end

  assign Out       = out_q;
  assign out_valid = out_valid_q;
  assign code_err  = code_err_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_wddl_word_decoder.sv
// Directed self-checking bench for wddl_word_decoder
// (WORD = 32, TIMEOUT = 15, alarm option off).
module tb_wddl_word_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_t;
  logic [31:0] in_f;
  logic [31:0] dout;
  logic        out_valid;
  logic        out_ready;
  logic        code_err;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  wddl_word_decoder #(
    .WORD(32),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .In_T(in_t),
    .In_F(in_f),
    .Out(dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .code_err(code_err),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic spacer();
    in_t = 32'h0;
    in_f = 32'h0;
  endtask

  task automatic word(logic [31:0] w);
    in_t = w;
    in_f = ~w;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    spacer();
    step();
    step();
    rst = 1'b0;
    chk("rst_out", dout, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_err", {31'h0, code_err}, 32'h0);
    chk("rst_tmo", {31'h0, timeout}, 32'h0);

    // basic word: PRE sees spacer, then valid word captured
    step();
    in_t = 32'hA5A5A5A5;
    in_f = 32'h5A5A5A5A;
    step();
    chk("w1_valid", {31'h0, out_valid}, 32'h1);
    chk("w1_out", dout, 32'hA5A5A5A5);
    in_t = 32'hFFFFFFFF;
    in_f = 32'hFFFFFFFF;
    step();
    step();
    step();
    chk("hold_valid", {31'h0, out_valid}, 32'h1);
    chk("hold_out", dout, 32'hA5A5A5A5);
    chk("hold_err", {31'h0, code_err}, 32'h0);
    spacer();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ack_valid", {31'h0, out_valid}, 32'h0);
    chk("ack_keep", dout, 32'hA5A5A5A5);

    // illegal bit 7 during EVAL
    step();
    in_t = 32'h000000FF;
    in_f = 32'hFFFFFF80;
    step();
    chk("ill_err", {31'h0, code_err}, 32'h1);
    chk("ill_valid", {31'h0, out_valid}, 32'h0);
    word(32'h00000001);
    step();
    chk("ill_pulse", {31'h0, code_err}, 32'h0);
    step();
    chk("ill_pre", {31'h0, out_valid}, 32'h0);

    // illegal code while in PRE
    in_t = 32'h80000000;
    in_f = 32'h80000000;
    step();
    chk("pre_err", {31'h0, code_err}, 32'h1);
    word(32'h00000001);
    step();
    chk("pre_err_end", {31'h0, code_err}, 32'h0);
    chk("pre_novalid", {31'h0, out_valid}, 32'h0);

    // timeout: bit 0 held as spacer
    spacer();
    step();
    in_t = 32'hFFFFFFFE;
    in_f = 32'h00000000;
    for (int i = 0; i < 15; i++) step();
    chk("tmo_early", {31'h0, timeout}, 32'h0);
    step();
    chk("tmo_pulse", {31'h0, timeout}, 32'h1);
    chk("tmo_novalid", {31'h0, out_valid}, 32'h0);
    step();
    chk("tmo_end", {31'h0, timeout}, 32'h0);
    word(32'hFFFFFFFF);
    step();
    chk("tmo_pre", {31'h0, out_valid}, 32'h0);
    chk("tmo_keep", dout, 32'hA5A5A5A5);

    // valid on the cycle the counter reaches TIMEOUT
    spacer();
    step();
    in_t = 32'hFFFFFFFE;
    in_f = 32'h00000000;
    for (int i = 0; i < 15; i++) step();
    word(32'h00000005);
    step();
    chk("edge_valid", {31'h0, out_valid}, 32'h1);
    chk("edge_out", dout, 32'h00000005);
    chk("edge_tmo", {31'h0, timeout}, 32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("edge_ack", {31'h0, out_valid}, 32'h0);

    // two words with no spacer between them
    spacer();
    step();
    word(32'hDEADBEEF);
    step();
    chk("two_first", dout, 32'hDEADBEEF);
    word(32'h00000001);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    step();
    chk("two_block", {31'h0, out_valid}, 32'h0);
    chk("two_keep", dout, 32'hDEADBEEF);
    spacer();
    step();
    word(32'h00000001);
    step();
    chk("two_valid", {31'h0, out_valid}, 32'h1);
    chk("two_second", dout, 32'h00000001);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // reset during HOLD drops the word
    spacer();
    step();
    word(32'hFFFFFFFF);
    step();
    chk("rh_valid", {31'h0, out_valid}, 32'h1);
    chk("rh_out", dout, 32'hFFFFFFFF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rh_drop", {31'h0, out_valid}, 32'h0);
    chk("rh_zero", dout, 32'h0);
    step();
    step();
    chk("rh_spacer", {31'h0, out_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wddl_word_decoder.md
WDDL_WORD_DECODER -- requirements
Module: wddl_word_decoder

Interface
REQ-001 SHALL have parameter WORD, default 32: dual-rail word width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 15, legal range 1..255: maximum cycles allowed in EVAL before abort.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port In_T  input  WORD: true rail of the WDDL word.
REQ-006 SHALL have port In_F  input  WORD: false rail of the WDDL word.
REQ-007 SHALL have port Out  output  WORD: decoded single-rail word, registered.
REQ-008 SHALL have port out_valid  output  1: Out holds a decoded word.
REQ-009 SHALL have port out_ready  input  1: consumer accepts Out.
REQ-010 SHALL have port code_err  output  1: one-cycle pulse when an illegal 11 code is seen on any bit.
REQ-011 SHALL have port timeout  output  1: one-cycle pulse when EVAL is aborted by TIMEOUT.

Function
REQ-012 SHALL decode per bit combinationally: spacer = 00, logic 1 = T1/F0, logic 0 = T0/F1, illegal = 11.
REQ-013 SHALL derive flags: all_spacer = every bit 00; all_valid = every bit 01 or 10; any_illegal = at least one bit 11.
REQ-014 SHALL implement FSM states PRE, EVAL and HOLD.
REQ-015 PRE: if all_spacer, go to EVAL next cycle; otherwise stay in PRE.
REQ-016 EVAL: each cycle, priority any_illegal > all_valid > timeout.
- any_illegal: pulse code_err; go to PRE.
- all_valid: Out <= In_T; out_valid <= 1; go to HOLD.
- Cycle counter reaches TIMEOUT with neither of the above: pulse timeout; go to PRE.
REQ-017 SHALL clear the EVAL cycle counter on entry to EVAL; counter width is 8 bits and it never wraps.
REQ-018 all_valid on the same cycle the counter reaches TIMEOUT: SHALL capture, with no timeout pulse.
REQ-019 Decode latency: Out and out_valid SHALL be asserted on the first rising edge after the cycle in which all_valid is true in EVAL.
REQ-020 HOLD: Out and out_valid held stable; rail inputs ignored; out_valid && out_ready clears out_valid and returns to PRE on the next edge.
REQ-021 PRE: any_illegal SHALL pulse code_err and remain in PRE.
REQ-022 out_ready SHALL be ignored when out_valid is 0.
REQ-023 SHALL accept a word only after an intervening full spacer, so one evaluation phase yields exactly one word.
REQ-024 Out SHALL retain its last captured value outside HOLD.

Reset
REQ-025 rst high on a clock edge: state PRE, Out = 0, out_valid = 0, code_err = 0, timeout = 0, counter = 0.
REQ-026 rst asserted in any state, including mid-HOLD, SHALL drop any pending word with no handshake.
REQ-027 After rst deasserts, the first word SHALL require a spacer first.

Configuration
REQ-028 SHALL use macro WDDL_ALARM_EN to control the fail-secure alarm.
- Defined: adds output port alarm (1 bit), set on any code_err or timeout pulse and cleared only by rst.
- Defined, alarm = 1: Out forced to 0, out_valid held 0, no captures.
- Undefined: no alarm port; errors only pulse their flags, decoding continues.

Verification (WORD = 32, TIMEOUT = 15)
REQ-029 Reset then spacer, then T=0xA5A5A5A5, F=0x5A5A5A5A -> out_valid = 1 one cycle after the valid code appears, Out = 0xA5A5A5A5, held until out_ready = 1.
REQ-030 Spacer, then bit 7 = 11 with the other bits valid -> code_err pulses for 1 cycle, FSM in PRE, out_valid stays 0; with WDDL_ALARM_EN, alarm = 1 and a following legal word is not delivered.
REQ-031 Spacer, then bit 0 stays 00 for 20 cycles -> timeout pulses in the 16th cycle of EVAL, FSM in PRE, no capture.
REQ-032 Two valid words with no spacer between them -> only the first is delivered; after a spacer, the second word 0x00000001 is delivered.
REQ-033 rst asserted during HOLD with Out = 0xFFFFFFFF -> next cycle out_valid = 0, Out = 0.
REQ-034 Word goes all_valid in EVAL cycle 15 (counter reaches TIMEOUT) -> captured, timeout stays 0.
